// File: rtl/des_sbox_unit.sv
// DES substitution stage: maps a 48-bit key-mixed word through S1..S8 to 32 bits,
// evaluating LANES boxes per cycle behind valid/ready handshakes on both sides.
module des_sbox_unit #(
  parameter int unsigned LANES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:48] in_bits_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [1:32] out_bits_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o
);

  localparam int unsigned NPASS = 8 / LANES;
  localparam int unsigned CntW  = (NPASS > 1) ? $clog2(NPASS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
  end

  // Each table holds 64 nibbles ordered row-major (row*16 + column), first entry in the MSBs.
  localparam logic [255:0] SboxTab1 =
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] SboxTab2 =
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] SboxTab3 =
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] SboxTab4 =
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] SboxTab5 =
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] SboxTab6 =
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] SboxTab7 =
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] SboxTab8 =
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [47:0]       in_reg_q, in_reg_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       acc_run;

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] grp);
    logic [255:0] tab;
    logic [255:0] sh;
    logic [5:0]   idx;
    case (box)
      3'd0:    tab = SboxTab1;
      3'd1:    tab = SboxTab2;
      3'd2:    tab = SboxTab3;
      3'd3:    tab = SboxTab4;
      3'd4:    tab = SboxTab5;
      3'd5:    tab = SboxTab6;
      3'd6:    tab = SboxTab7;
      default: tab = SboxTab8;
    endcase
    // Row is the outer bit pair, column the inner four bits.
    idx = {grp[5], grp[0], grp[4:1]};
    sh  = tab << {idx, 2'b00};
    return sh[255:252];
  endfunction

  // Accumulator with this pass's LANES nibbles substituted in.
  always_comb begin : p_lanes
    int unsigned box_idx;
    logic [47:0] grp_word;
    logic [3:0]  nib;
    acc_run  = acc_q;
    box_idx  = 0;
    grp_word = '0;
    nib      = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      box_idx  = 32'(cnt_q) * LANES + l;
      grp_word = in_reg_q << (6 * box_idx);
      nib      = sbox_lookup(box_idx[2:0], grp_word[47:42]);
      acc_run  = (acc_run & ~(32'hF000_0000 >> (4 * box_idx)))
               | ({nib, 28'h0} >> (4 * box_idx));
    end
  end

  always_comb begin : p_fsm
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_reg_d    = in_reg_q;
    acc_d       = acc_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          in_reg_d = in_bits_i;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        busy_o = 1'b1;
        acc_d  = acc_run;
        if (cnt_q == CntW'(NPASS - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          in_ready_o = 1'b1;
          // Back-to-back accept skips IDLE entirely.
          if (in_valid_i) begin
            in_reg_d = in_bits_i;
            cnt_d    = '0;
            state_d  = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      in_reg_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_reg_q <= in_reg_d;
      acc_q    <= acc_d;
    end
  end

  assign out_bits_o = acc_q;

endmodule
